// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-device SPI master.
// Provides the control FSM state encoding and the clock polarity / phase constants.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        READ,
        HOLD,
        GAP
    } spi_state_e;

    // sclk level held in reset, before any transfer has latched a polarity
    localparam logic CPOL_LOW = 1'b0;

    // Phase of sclk just before the sampling edge (CPHA=0: sample on the leading edge)
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick and sclk phase generator for the SPI master.
// Ports:
//   clk, reset_n  - system clock, async active-low reset
//   en            - count while a transfer is in progress
//   reload        - clear the divider counter (transfer accept)
//   phase_en      - allow the phase to toggle on ticks (shift states only)
//   cpol          - next-cycle clock polarity, so sclk follows a new polarity without lag
//   div           - half-period length minus 1, in clk cycles
//   tick_c        - combinational half-period strobe
//   phase_q       - internal sclk phase (0 = idle level)
//   sclk_q        - registered serial clock, cpol XOR phase
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             reload,
    input  logic             phase_en,
    input  logic             cpol,
    input  logic [DIV_W-1:0] div,
    output logic             tick_c,
    output logic             phase_q,
    output logic             sclk_q
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_d;
    logic             sclk_d;

    // Divider counter wraps to 0 on each tick; phase toggles on ticks only while enabled
    always_comb begin
        tick_c  = en && (cnt_q == div);
        cnt_d   = '0;
        phase_d = 1'b0;
        if (reload || !en || tick_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        if (phase_en) begin
            phase_d = tick_c ? ~phase_q : phase_q;
        end
        sclk_d = cpol ^ phase_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            sclk_q  <= CPOL_LOW;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// Multi-device SPI master (CPHA=0, selectable CPOL, 3-wire or 4-wire read).
// Sends a caller-built MSB-first bit stream, then optionally reads back bits.
// Ports:
//   clk, reset_n          - system clock, async active-low reset
//   data_out              - write data, bit DATA_W-1 sent first
//   data_in               - right-justified read data, updated with done
//   write_bits/read_bits  - bit counts per phase, 0..DATA_W
//   cs_select             - target device index
//   clk_div               - sclk half-period minus 1, in clk cycles
//   cpol, three_wire      - sclk idle level; read from sdio (1) or miso (0)
//   request_action        - start request, honoured only when idle
//   busy, done, error     - status: in transfer, completion pulse, reject pulse
//   sclk, sdio, miso      - serial clock, bidirectional data, 4-wire read input
//   cs_n                  - active-low chip selects
module spi_master_multi
    import spi_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned NUM_CS = 4,
    parameter  int unsigned DIV_W  = 8,
    parameter  int unsigned CNT_W  = $clog2(DATA_W + 1),
    localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  write_bits,
    input  logic [CNT_W-1:0]  read_bits,
    input  logic [CS_W-1:0]   cs_select,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cpol,
    input  logic              three_wire,
    input  logic              request_action,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              sclk,
    inout  wire               sdio,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [CNT_W-1:0]  w_bits_q, w_bits_d;
    logic [CNT_W-1:0]  r_bits_q, r_bits_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              cpol_q, cpol_d;
    logic              three_wire_q, three_wire_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              sdio_oe_q, sdio_oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic tick_c, phase_q, sclk_q;
    logic cs_ok_c, req_bad_c, start_c, accept_c;
    logic lead_c, trail_c, din_c, shift_en_c;

    // Range check by enumeration, so a power-of-two NUM_CS needs no unreachable compare
    always_comb begin
        cs_ok_c = 1'b0;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (cs_select == CS_W'(i)) begin
                cs_ok_c = 1'b1;
            end
        end
    end

    assign req_bad_c  = !cs_ok_c
                        || (write_bits > CNT_W'(DATA_W))
                        || (read_bits  > CNT_W'(DATA_W));
    // busy_q also covers the first idle cycle after GAP, so no back-to-back accept there
    assign start_c    = (state_q == IDLE) && !busy_q && request_action;
    assign accept_c   = start_c && !req_bad_c;
    assign shift_en_c = (state_q == WRITE) || (state_q == READ);
    assign lead_c     = tick_c && (phase_q == CPHA);
    assign trail_c    = tick_c && (phase_q != CPHA);
    assign din_c      = three_wire_q ? sdio : miso;

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (state_q != IDLE),
        .reload   (accept_c),
        .phase_en (shift_en_c),
        .cpol     (cpol_d),
        .div      (div_q),
        .tick_c   (tick_c),
        .phase_q  (phase_q),
        .sclk_q   (sclk_q)
    );

    // Control FSM: next state, shift registers and status pulses
    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        data_in_d    = data_in_q;
        w_bits_d     = w_bits_q;
        r_bits_d     = r_bits_q;
        bit_cnt_d    = bit_cnt_q;
        div_d        = div_q;
        cpol_d       = cpol_q;
        three_wire_d = three_wire_q;
        cs_n_d       = cs_n_q;
        sdio_oe_d    = sdio_oe_q;
        done_d       = 1'b0;
        error_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_c && req_bad_c) begin
                    error_d = 1'b1;
                end else if (accept_c) begin
                    tx_d         = data_out;
                    rx_d         = '0;
                    w_bits_d     = write_bits;
                    r_bits_d     = read_bits;
                    bit_cnt_d    = '0;
                    div_d        = clk_div;
                    cpol_d       = cpol;
                    three_wire_d = three_wire;
                    cs_n_d       = ~(NUM_CS'(1) << cs_select);
                    sdio_oe_d    = (write_bits != '0);
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (tick_c) begin
                    if (w_bits_q != '0) begin
                        state_d = WRITE;
                    end else if (r_bits_q != '0) begin
                        state_d = READ;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            WRITE: begin
                if (trail_c) begin
                    tx_d      = {tx_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if ((bit_cnt_q + CNT_W'(1)) == w_bits_q) begin
                        sdio_oe_d = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = (r_bits_q != '0) ? READ : HOLD;
                    end
                end
            end
            READ: begin
                if (lead_c) begin
                    rx_d = {rx_q[DATA_W-2:0], din_c};
                end
                if (trail_c) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if ((bit_cnt_q + CNT_W'(1)) == r_bits_q) begin
                        bit_cnt_d = '0;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick_c) begin
                    cs_n_d    = '1;
                    data_in_d = rx_q;
                    done_d    = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (tick_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                cs_n_d    = '1;
                sdio_oe_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE) || (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tx_q         <= '0;
            rx_q         <= '0;
            data_in_q    <= '0;
            w_bits_q     <= '0;
            r_bits_q     <= '0;
            bit_cnt_q    <= '0;
            div_q        <= '0;
            cpol_q       <= CPOL_LOW;
            three_wire_q <= 1'b0;
            cs_n_q       <= '1;
            sdio_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            data_in_q    <= data_in_d;
            w_bits_q     <= w_bits_d;
            r_bits_q     <= r_bits_d;
            bit_cnt_q    <= bit_cnt_d;
            div_q        <= div_d;
            cpol_q       <= cpol_d;
            three_wire_q <= three_wire_d;
            cs_n_q       <= cs_n_d;
            sdio_oe_q    <= sdio_oe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign sdio    = sdio_oe_q ? tx_q[DATA_W-1] : 1'bz;
    assign data_in = data_in_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with a bit-level slave model and a data_in scoreboard.
module tb_spi_master_multi;

    localparam int unsigned NCS    = 4;
    localparam int          BUDGET = 3000;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_out = '0;
    logic [31:0] data_in;
    logic [5:0]  write_bits = '0;
    logic [5:0]  read_bits  = '0;
    logic [1:0]  cs_select  = '0;
    logic [7:0]  clk_div    = '0;
    logic        cpol       = 1'b0;
    logic        three_wire = 1'b0;
    logic        request_action = 1'b0;
    logic        busy, done, error, sclk;
    wire         sdio;
    logic        miso = 1'b0;
    logic [3:0]  cs_n;

    logic        slv_oe  = 1'b0;
    logic        slv_bit = 1'b0;
    pullup (sdio);
    assign sdio = slv_oe ? slv_bit : 1'bz;

    // Second instance with a non power-of-two device count to reach an out-of-range select
    logic [2:0]  cs_select5 = '0;
    logic        request5   = 1'b0;
    logic [31:0] data_in5;
    logic        busy5, done5, error5, sclk5;
    wire         sdio5;
    logic [4:0]  cs_n5;
    pullup (sdio5);

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    spi_master_multi u_dut (
        .clk(clk), .reset_n(reset_n), .data_out(data_out), .data_in(data_in),
        .write_bits(write_bits), .read_bits(read_bits), .cs_select(cs_select),
        .clk_div(clk_div), .cpol(cpol), .three_wire(three_wire),
        .request_action(request_action), .busy(busy), .done(done), .error(error),
        .sclk(sclk), .sdio(sdio), .miso(miso), .cs_n(cs_n)
    );

    spi_master_multi #(.NUM_CS(5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .data_out(data_out), .data_in(data_in5),
        .write_bits(write_bits), .read_bits(read_bits), .cs_select(cs_select5),
        .clk_div(clk_div), .cpol(cpol), .three_wire(three_wire),
        .request_action(request5), .busy(busy5), .done(done5), .error(error5),
        .sclk(sclk5), .sdio(sdio5), .miso(miso), .cs_n(cs_n5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_done(input string tag);
        logic [31:0] e;
        check({tag, "_sb_level"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_data_in"}, 64'(data_in), 64'(e));
        end
    endtask

    // One full transfer acting as the slave; checks stream, selects, timing and result
    task automatic xfer(input string tag, input logic [31:0] dout, input int w, input int r,
                        input int d, input logic pol, input logic tw, input int sel,
                        input logic [31:0] rdata);
        int          busy_len, lead_cnt, trail_cnt, done_cnt, cs_bad, z_bad, cs_low;
        logic        seen, first, idle_ok, sclk_prev;
        logic [31:0] mosi;
        logic [3:0]  exp_cs;
        logic [63:0] mask;
        busy_len = 0; lead_cnt = 0; trail_cnt = 0; done_cnt = 0;
        cs_bad = 0; z_bad = 0; cs_low = 0;
        seen = 1'b0; first = 1'b1; idle_ok = 1'b0; mosi = '0;
        exp_cs = ~(4'b0001 << sel);
        mask = (64'd1 << r) - 64'd1;

        @(negedge clk);
        data_out = dout; write_bits = 6'(w); read_bits = 6'(r); cs_select = 2'(sel);
        clk_div = 8'(d); cpol = pol; three_wire = tw; request_action = 1'b1;
        exp_q.push_back(32'(64'(rdata) & mask));
        @(negedge clk);
        request_action = 1'b0;
        data_out = '0; write_bits = '0; read_bits = '0; cpol = ~pol;
        sclk_prev = pol;

        for (int c = 0; c < BUDGET; c++) begin
            if (busy) begin
                busy_len++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            if (first) begin
                idle_ok = (sclk === pol);
                first = 1'b0;
            end
            if (sclk !== sclk_prev) begin
                if (sclk !== pol) begin
                    if (lead_cnt < w) mosi = {mosi[30:0], sdio};
                    else if (!tw && sdio !== 1'b1) z_bad++;
                    lead_cnt++;
                end else begin
                    trail_cnt++;
                end
                sclk_prev = sclk;
            end
            if (cs_n !== 4'hF) begin
                cs_low++;
                if (cs_n !== exp_cs) cs_bad++;
            end
            if (done) begin
                done_cnt++;
                sb_done(tag);
            end
            if (cs_n[sel] == 1'b0 && trail_cnt >= w && trail_cnt < w + r) begin
                if (tw) begin
                    slv_oe  = 1'b1;
                    slv_bit = rdata[r - 1 - (trail_cnt - w)];
                end else begin
                    miso = rdata[r - 1 - (trail_cnt - w)];
                end
            end else begin
                slv_oe = 1'b0;
            end
            @(negedge clk);
        end
        slv_oe = 1'b0;
        miso   = 1'b0;

        check({tag, "_busy_len"}, 64'(busy_len), 64'(1 + (d + 1) * (2 * (w + r) + 3)));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_mosi"}, 64'(mosi), 64'(dout >> (32 - w)));
        check({tag, "_sclk_edges"}, 64'(lead_cnt), 64'(w + r));
        check({tag, "_cs_onehot"}, 64'(cs_bad), 64'd0);
        check({tag, "_cs_active"}, 64'(cs_low > 0), 64'd1);
        check({tag, "_sdio_rel_rd"}, 64'(z_bad), 64'd0);
        check({tag, "_sclk_idle_start"}, 64'(idle_ok), 64'd1);
        check({tag, "_sclk_idle_end"}, 64'(sclk), 64'(pol));
        check({tag, "_cs_released"}, 64'(cs_n), 64'hF);
        check({tag, "_sdio_released"}, 64'(sdio), 64'd1);
    endtask

    // Bad request on the 4-device instance: one error pulse, no activity
    task automatic reject(input string tag, input int w, input int r);
        @(negedge clk);
        write_bits = 6'(w); read_bits = 6'(r); cs_select = 2'd0; request_action = 1'b1;
        @(negedge clk);
        request_action = 1'b0;
        check({tag, "_error"}, 64'(error), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_error_pulse"}, 64'(error), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_cs_idle"}, 64'(cs_n), 64'hF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int trail, rises, dones, len1, len2;
        logic sp, pb;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_cs_n", 64'(cs_n), 64'hF);
        check("rst_sdio", 64'(sdio), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_data_in", 64'(data_in), 64'd0);
        check("rst_sclk", 64'(sclk), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        xfer("wr3w", 32'hA5C30000, 16, 8, 2, 1'b0, 1'b1, 1, 32'h3C);
        xfer("cpol1", 32'h80000000, 8, 8, 0, 1'b1, 1'b0, 2, 32'hFF);
        xfer("w0r0", 32'h12345678, 0, 0, 0, 1'b0, 1'b0, 3, 32'h0);
        xfer("w32r32", 32'hDEADBEEF, 32, 32, 1, 1'b0, 1'b1, 0, 32'hC0FFEE11);
        xfer("r5only", 32'hFFFFFFFF, 0, 5, 1, 1'b1, 1'b1, 2, 32'h15);
        xfer("w12", 32'h9F300000, 12, 0, 3, 1'b0, 1'b0, 1, 32'h0);

        reject("wbits33", 33, 4);
        reject("rbits33", 4, 33);

        // Out-of-range select on the 5-device instance
        @(negedge clk);
        write_bits = 6'd8; read_bits = 6'd0; cs_select5 = 3'd5; request5 = 1'b1;
        @(negedge clk);
        request5 = 1'b0;
        check("cs5_error", 64'(error5), 64'd1);
        check("cs5_busy", 64'(busy5), 64'd0);
        @(negedge clk);
        check("cs5_error_pulse", 64'(error5), 64'd0);
        check("cs5_cs_idle", 64'(cs_n5), 64'h1F);
        check("cs5_sclk", 64'(sclk5), 64'd0);
        check("cs5_sdio", 64'(sdio5), 64'd1);
        check("cs5_done", 64'(done5), 64'd0);
        check("cs5_data_in", 64'(data_in5), 64'd0);

        // Reset during the sixth write bit
        @(negedge clk);
        data_out = 32'h0; write_bits = 6'd16; read_bits = 6'd0; cs_select = 2'd0;
        clk_div = 8'd3; cpol = 1'b0; three_wire = 1'b0; request_action = 1'b1;
        @(negedge clk);
        request_action = 1'b0;
        trail = 0;
        sp = 1'b0;
        for (int c = 0; c < BUDGET && trail < 5; c++) begin
            @(negedge clk);
            if (sp == 1'b1 && sclk == 1'b0) trail++;
            sp = sclk;
        end
        check("rst_mid_reached", 64'(trail), 64'd5);
        check("rst_mid_pre_cs", 64'(cs_n), 64'hE);
        check("rst_mid_pre_sdio", 64'(sdio), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_cs_n", 64'(cs_n), 64'hF);
        check("rst_mid_sdio", 64'(sdio), 64'd1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_sclk", 64'(sclk), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        xfer("post_rst", 32'h5A5A0000, 16, 8, 1, 1'b0, 1'b0, 3, 32'hA7);

        // Request held across done: exactly one more transfer
        rises = 0; dones = 0; len1 = 0; len2 = 0; pb = 1'b0;
        @(negedge clk);
        data_out = 32'h5A000000; write_bits = 6'd8; read_bits = 6'd0; cs_select = 2'd2;
        clk_div = 8'd0; cpol = 1'b0; three_wire = 1'b0; request_action = 1'b1;
        exp_q.push_back(32'h0);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (busy && !pb) begin
                rises++;
                if (rises == 2) begin
                    request_action = 1'b0;
                    exp_q.push_back(32'h0);
                end
            end
            if (busy) begin
                if (rises == 1) len1++;
                else if (rises == 2) len2++;
            end
            if (done) begin
                dones++;
                sb_done("held");
            end
            pb = busy;
        end
        request_action = 1'b0;
        check("held_starts", 64'(rises), 64'd2);
        check("held_dones", 64'(dones), 64'd2);
        check("held_len1", 64'(len1), 64'd20);
        check("held_len2", 64'(len2), 64'd20);
        check("held_busy_end", 64'(busy), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
